// File: rtl/lfsr_rng_arbiter.sv
// Seeds, unlocks and shares an external 5-bit LFSR (taps s[4]^s[2]) between two requesters,
// returning a bounded random value per request by rejection sampling.
module lfsr_rng_arbiter #(
    parameter int MAX_TRIES = 31
) (
    input  logic       clk,
    input  logic       preset,
    input  logic       seed_we,
    input  logic [4:0] seed,
    input  logic [1:0] req,
    input  logic [4:0] limit0,
    input  logic [4:0] limit1,
    input  logic [4:0] lfsr_s,
    output logic       lfsr_li,
    output logic [4:0] lfsr_load,
    output logic [1:0] ack,
    output logic [4:0] value,
    output logic       forced,
    output logic       busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DRAW = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;
    localparam logic [5:0] MAX_C  = 6'(MAX_TRIES);

    logic [1:0] state_q, state_d;
    logic       li_q, li_d;
    logic [4:0] load_q, load_d;
    logic [1:0] ack_q, ack_d;
    logic [4:0] value_q, value_d;
    logic       forced_q, forced_d;
    logic       pend_q, pend_d;
    logic [4:0] hold_q, hold_d;
    logic       rr_q, rr_d;
    logic       g_q, g_d;
    logic [4:0] lim_q, lim_d;
    logic [5:0] try_q, try_d;

    logic       lock, gnt, seed_taken;
    logic [4:0] seed_use;

    assign lock     = (lfsr_s == 5'd0);
    assign seed_use = seed_we ? seed : hold_q;
    assign gnt      = (req == 2'b11) ? ~rr_q : req[1];

    always_comb begin
        state_d    = state_q;
        li_d       = 1'b0;
        load_d     = load_q;
        ack_d      = 2'b00;
        value_d    = value_q;
        forced_d   = 1'b0;
        pend_d     = pend_q;
        hold_d     = hold_q;
        rr_d       = rr_q;
        g_d        = g_q;
        lim_d      = lim_q;
        try_d      = try_q;
        seed_taken = 1'b0;
        case (state_q)
            S_IDLE: begin
                // While a reload is already in flight the LFSR still reads 0; just wait it out.
                if (lock) begin
                    if (!li_q) begin
                        li_d   = 1'b1;
                        load_d = 5'd1;
                    end
                end else if (seed_we || pend_q) begin
                    li_d       = 1'b1;
                    load_d     = (seed_use == 5'd0) ? 5'd1 : seed_use;
                    pend_d     = 1'b0;
                    seed_taken = 1'b1;
                    state_d    = S_LOAD;
                end else if (req != 2'b00) begin
                    g_d     = gnt;
                    lim_d   = gnt ? limit1 : limit0;
                    try_d   = 6'd0;
                    state_d = S_DRAW;
                end
            end
            S_LOAD: state_d = S_IDLE;
            S_DRAW: begin
                if (!req[g_q]) begin
                    state_d = S_IDLE;
                end else if (lock) begin
                    if (!li_q) begin
                        li_d   = 1'b1;
                        load_d = 5'd1;
                    end
                end else if (lim_q == 5'd0 || lfsr_s <= lim_q) begin
                    value_d    = lfsr_s - 5'd1;
                    ack_d[g_q] = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    try_d = try_q + 6'd1;
                    if (try_d == MAX_C) begin
                        value_d    = 5'd0;
                        ack_d[g_q] = 1'b1;
                        forced_d   = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end
            default: begin
                rr_d    = g_q;
                state_d = S_IDLE;
            end
        endcase
        // A seed not consumed this cycle is parked; the newest one wins.
        if (seed_we && !seed_taken) begin
            pend_d = 1'b1;
            hold_d = seed;
        end
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q  <= S_IDLE;
            li_q     <= 1'b0;
            load_q   <= 5'd0;
            ack_q    <= 2'b00;
            value_q  <= 5'd0;
            forced_q <= 1'b0;
            pend_q   <= 1'b0;
            hold_q   <= 5'd0;
            rr_q     <= 1'b1;
            g_q      <= 1'b0;
            lim_q    <= 5'd0;
            try_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            li_q     <= li_d;
            load_q   <= load_d;
            ack_q    <= ack_d;
            value_q  <= value_d;
            forced_q <= forced_d;
            pend_q   <= pend_d;
            hold_q   <= hold_d;
            rr_q     <= rr_d;
            g_q      <= g_d;
            lim_q    <= lim_d;
            try_q    <= try_d;
        end
    end

    assign lfsr_li   = li_q;
    assign lfsr_load = load_q;
    assign ack       = ack_q;
    assign value     = value_q;
    assign forced    = forced_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench: models the external LFSR (with an override for forcing states) and
// walks seeding, draws, round-robin, deferred seeding, reset abort and lock-up recovery.
module tb_lfsr_rng_arbiter;
    logic       clk = 1'b0;
    logic       preset = 1'b1;
    logic       seed_we = 1'b0;
    logic [4:0] seed = 5'd0;
    logic [1:0] req = 2'b00;
    logic [4:0] limit0 = 5'd0;
    logic [4:0] limit1 = 5'd0;
    logic [4:0] lfsr_s = 5'd1;
    logic       lfsr_li;
    logic [4:0] lfsr_load;
    logic [1:0] ack;
    logic [4:0] value;
    logic       forced;
    logic       busy;

    logic       ovr_en = 1'b0;
    logic [4:0] ovr_val = 5'd0;

    int checks = 0;
    int errors = 0;
    int n, tot, seen;
    logic [1:0] rr_exp [3];

    lfsr_rng_arbiter #(.MAX_TRIES(31)) dut (
        .clk(clk), .preset(preset), .seed_we(seed_we), .seed(seed), .req(req),
        .limit0(limit0), .limit1(limit1), .lfsr_s(lfsr_s), .lfsr_li(lfsr_li),
        .lfsr_load(lfsr_load), .ack(ack), .value(value), .forced(forced), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ovr_en)       lfsr_s <= ovr_val;
        else if (lfsr_li) lfsr_s <= lfsr_load;
        else              lfsr_s <= {lfsr_s[3:0], lfsr_s[4] ^ lfsr_s[2]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (ack == 2'b00 && cnt < 60);
    endtask

    // Raise r and make lfsr_s = s during the first DRAW cycle.
    task automatic start_draw(input logic [1:0] r, input logic [4:0] s);
        @(negedge clk);
        req = r; ovr_en = 1'b1; ovr_val = s;
        @(negedge clk);
        ovr_en = 1'b0;
    endtask

    initial begin
        rr_exp = '{2'b01, 2'b10, 2'b01};
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_li", lfsr_li, 0);
        chk("rst_load", lfsr_load, 0);
        chk("rst_value", value, 0);
        chk("rst_forced", forced, 0);
        preset = 1'b0;

        // Seed 0 is replaced by 1.
        @(negedge clk); seed_we = 1'b1; seed = 5'd0;
        @(negedge clk); seed_we = 1'b0;
        chk("seed0_li", lfsr_li, 1);
        chk("seed0_load", lfsr_load, 1);
        chk("seed0_busy", busy, 1);
        @(negedge clk);
        chk("seed0_lfsr", lfsr_s, 1);
        chk("seed0_li_off", lfsr_li, 0);
        chk("seed0_busy_off", busy, 0);

        // Immediate accept on s=1.
        limit0 = 5'd3;
        start_draw(2'b01, 5'd1);
        chk("d0_busy", busy, 1);
        wait_ack(n);
        chk("d0_lat", n, 1);
        chk("d0_ack", ack, 2'b01);
        chk("d0_value", value, 0);
        chk("d0_forced", forced, 0);
        req = 2'b00;
        @(negedge clk);
        chk("d0_ack_off", ack, 0);
        chk("d0_idle", busy, 0);

        // 29 rejects from s=4 then accept on 1.
        limit1 = 5'd2;
        start_draw(2'b10, 5'd4);
        wait_ack(n);
        chk("d1_lat", n, 30);
        chk("d1_ack", ack, 2'b10);
        chk("d1_value", value, 0);
        chk("d1_forced", forced, 0);
        req = 2'b00;
        @(negedge clk);
        chk("d1_ack_off", ack, 0);

        // Round robin with both requesting.
        limit0 = 5'd0; limit1 = 5'd0; req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_ack(n);
            chk("rr_lat", n, 2);
            chk("rr_ack", ack, rr_exp[k]);
            req = req & ~ack;
            @(negedge clk);
            chk("rr_ack_off", ack, 0);
            req = (k < 2) ? 2'b11 : 2'b00;
        end

        // Seed during DRAW is deferred until after the response, ahead of a new grant.
        limit0 = 5'd2;
        start_draw(2'b01, 5'd4);
        @(negedge clk); seed_we = 1'b1; seed = 5'd9;
        @(negedge clk); seed_we = 1'b0;
        wait_ack(n);
        chk("sd_lat", n, 28);
        chk("sd_ack", ack, 2'b01);
        chk("sd_value", value, 0);
        req = 2'b00;
        @(negedge clk);
        chk("sd_idle", busy, 0);
        chk("sd_no_li", lfsr_li, 0);
        req = 2'b10; limit1 = 5'd0;
        @(negedge clk);
        chk("sd_load_busy", busy, 1);
        chk("sd_li", lfsr_li, 1);
        chk("sd_load", lfsr_load, 9);
        chk("sd_no_ack", ack, 0);
        @(negedge clk);
        chk("sd_lfsr", lfsr_s, 9);
        wait_ack(n);
        chk("sd_gnt_lat", n, 2);
        chk("sd_gnt_ack", ack, 2'b10);
        chk("sd_gnt_value", value, 17);
        req = 2'b00;
        @(negedge clk);

        // Reset in the middle of a draw.
        limit0 = 5'd2;
        start_draw(2'b01, 5'd31);
        repeat (2) @(negedge clk);
        preset = 1'b1;
        #1;
        chk("pr_busy", busy, 0);
        chk("pr_value", value, 0);
        chk("pr_forced", forced, 0);
        chk("pr_li", lfsr_li, 0);
        chk("pr_load", lfsr_load, 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack != 2'b00) seen++;
        end
        chk("pr_no_ack", seen, 0);
        preset = 1'b0; req = 2'b00;
        @(negedge clk);
        chk("pr_ack", ack, 0);

        // Lock-up in IDLE: one reload pulse, LFSR back to 1.
        ovr_en = 1'b1; ovr_val = 5'd0;
        @(negedge clk); ovr_en = 1'b0;
        @(negedge clk);
        chk("lk_li", lfsr_li, 1);
        chk("lk_load", lfsr_load, 1);
        chk("lk_busy", busy, 0);
        @(negedge clk);
        chk("lk_li_off", lfsr_li, 0);
        chk("lk_lfsr", lfsr_s, 1);

        // Lock-up mid-DRAW does not count as a try; forced result after 31 rejects.
        @(negedge clk);
        req = 2'b01; limit0 = 5'd2; ovr_en = 1'b1; ovr_val = 5'd31;
        repeat (4) @(negedge clk);
        ovr_val = 5'd0;
        @(negedge clk); ovr_val = 5'd31;
        @(negedge clk);
        chk("fd_li", lfsr_li, 1);
        chk("fd_load", lfsr_load, 1);
        chk("fd_no_ack", ack, 0);
        wait_ack(n);
        tot = 5 + n;
        chk("fd_lat", tot, 32);
        chk("fd_ack", ack, 2'b01);
        chk("fd_forced", forced, 1);
        chk("fd_value", value, 0);
        req = 2'b00; ovr_en = 1'b0;
        @(negedge clk);
        chk("fd_forced_off", forced, 0);
        chk("fd_ack_off", ack, 0);
        chk("fd_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
